// File: rtl/player_input_conditioner.sv
// player_input_conditioner: synchronise, debounce and frame-pace four direction buttons into move strobes
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   btn_{left,right,up,down}_raw  raw active-high buttons, asynchronous to clk
//   frame_tick                  one-cycle pulse per game frame
//   left, right, up, down       registered one-cycle move strobes
//   held                        debounced button state {left,right,up,down}
module player_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 8,
   parameter int REPEAT_RATE     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_left_raw,
   input  logic       btn_right_raw,
   input  logic       btn_up_raw,
   input  logic       btn_down_raw,
   input  logic       frame_tick,
   output logic       left,
   output logic       right,
   output logic       up,
   output logic       down,
   output logic [3:0] held
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int MX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CW = (MX > 1) ? $clog2(MX) : 1;
   typedef enum logic [1:0] {IDLE, ARMED, HOLD, REPEAT} state_t;
   logic [3:0] raw, s1, s2, db, fire, strobe;
   logic [DW-1:0] dcnt [4];
   logic [CW-1:0] cnt [4];
   logic [CW-1:0] ncnt [4];
   state_t st [4];
   state_t nst [4];
   assign raw = {btn_left_raw, btn_right_raw, btn_up_raw, btn_down_raw};
   assign {left, right, up, down} = strobe;
   assign held = db;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1     <= '0;
         s2     <= '0;
         db     <= '0;
         strobe <= '0;
         for (int i = 0; i < 4; i++) begin
            dcnt[i] <= '0;
            cnt[i]  <= '0;
            st[i]   <= IDLE;
         end
      end else begin
         s1 <= raw;
         s2 <= s1;
         for (int i = 0; i < 4; i++) begin
            dcnt[i] <= (s2[i] == db[i] || dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : dcnt[i] + 1'b1;
            if (s2[i] != db[i] && dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) db[i] <= s2[i];
            st[i]  <= nst[i];
            cnt[i] <= ncnt[i];
         end
         // each strobe is suppressed by its opposite on the same axis (left<->right, up<->down)
         strobe <= fire & ~{fire[2], fire[3], fire[0], fire[1]};
      end
   end
   // a release seen by the FSM wins over a coincident frame_tick; IDLE ignores ticks so a
   // fresh press always waits for the next tick in ARMED
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         nst[i]  = st[i];
         ncnt[i] = cnt[i];
         fire[i] = 1'b0;
         if (!db[i]) nst[i] = IDLE;
         else if (st[i] == IDLE) nst[i] = ARMED;
         else if (frame_tick) begin
            fire[i] = st[i] == ARMED ||
                      (st[i] == HOLD   && cnt[i] == CW'(REPEAT_DELAY - 1)) ||
                      (st[i] == REPEAT && cnt[i] == CW'(REPEAT_RATE - 1));
            ncnt[i] = fire[i] ? '0 : cnt[i] + 1'b1;
            nst[i]  = (st[i] == ARMED) ? HOLD : fire[i] ? REPEAT : st[i];
         end
      end
   end
endmodule

// File: tb/tb_player_input_conditioner.sv
// tb_player_input_conditioner: directed and random stimulus against a tick-counting reference model
module tb_player_input_conditioner;
   localparam int D = 16, RD = 8, RR = 4;
   logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
   logic [3:0] btn = '0, held, obs;
   logic left, right, up, down;
   logic [3:0] db_m, exp_s, exp_h;
   logic [3:0] pipe [$];
   int run [4], k [4], scount [4], mcount [4];
   bit act [4];
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   player_input_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_left_raw(btn[3]), .btn_right_raw(btn[2]), .btn_up_raw(btn[1]), .btn_down_raw(btn[0]),
      .frame_tick(tick), .left(left), .right(right), .up(up), .down(down), .held(held)
   );

   task automatic model_reset();
      db_m = '0;
      pipe = {4'b0, 4'b0};
      exp_s = '0;
      exp_h = '0;
      for (int i = 0; i < 4; i++) begin
         run[i] = 0;
         k[i] = 0;
         act[i] = 0;
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 4; i++) begin
         scount[i] = 0;
         mcount[i] = 0;
      end
   endtask

   // one clock: drive at negedge, model the rising edge, check #1 after it
   task automatic cyc(input logic [3:0] b, input logic t, input logic r = 1'b1);
      logic [3:0] f, lvl;
      @(negedge clk);
      btn = b;
      tick = t;
      rst_n = r;
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
         f = '0;
         // k counts frame ticks since the held button was armed; moves on tick 1, RD+1, RD+1+RR, ...
         for (int i = 0; i < 4; i++) begin
            if (!db_m[i]) begin
               act[i] = 0;
               k[i] = 0;
            end else if (!act[i]) act[i] = 1;
            else if (t) begin
               k[i]++;
               f[i] = (k[i] == 1) || (k[i] > RD && (k[i] - 1 - RD) % RR == 0);
            end
         end
         lvl = pipe.pop_front();
         pipe.push_back(b);
         for (int i = 0; i < 4; i++) begin
            if (lvl[i] != db_m[i]) begin
               run[i]++;
               if (run[i] == D) begin
                  db_m[i] = lvl[i];
                  run[i] = 0;
               end
            end else run[i] = 0;
         end
         exp_s = {f[3] & ~f[2], f[2] & ~f[3], f[1] & ~f[0], f[0] & ~f[1]};
         exp_h = db_m;
      end
      #1;
      obs = {left, right, up, down};
      checks++;
      assert (obs === exp_s) else begin
         failures++;
         $error("FAIL strobes t=%0t observed=%b expected=%b", $time, obs, exp_s);
      end
      checks++;
      assert (held === exp_h) else begin
         failures++;
         $error("FAIL held t=%0t observed=%b expected=%b", $time, held, exp_h);
      end
      for (int i = 0; i < 4; i++) begin
         scount[i] += int'(obs[i]);
         mcount[i] += int'(exp_s[i]);
      end
   endtask

   task automatic check_count(input string tag, input int got, input int want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
      end
   endtask

   initial begin
      model_reset();
      clear_counts();
      // reset with everything pressed and ticks pulsing
      for (int i = 0; i < 6; i++) cyc(4'hF, 1'(i % 2), 1'b0);
      for (int i = 0; i < 5; i++) cyc(4'h0, 1'b0);
      // glitch on left shorter than the debounce window
      clear_counts();
      for (int i = 0; i < 10; i++) cyc(4'b1000, 1'(i % 5 == 0));
      for (int i = 0; i < 30; i++) cyc(4'b0000, 1'(i % 5 == 0));
      check_count("glitch_left", scount[3], 0);
      // clean left press: one move after the next tick
      clear_counts();
      for (int i = 0; i < 20; i++) cyc(4'b1000, 1'b0);
      cyc(4'b1000, 1'b1);
      for (int i = 0; i < 3; i++) cyc(4'b1000, 1'b0);
      for (int i = 0; i < 25; i++) cyc(4'b0000, 1'b0);
      check_count("single_left", scount[3], 1);
      // auto-repeat on right over 30 ticks
      clear_counts();
      for (int i = 0; i < 22; i++) cyc(4'b0100, 1'b0);
      for (int j = 0; j < 30; j++) begin
         cyc(4'b0100, 1'b1);
         for (int i = 0; i < 3; i++) cyc(4'b0100, 1'b0);
      end
      check_count("repeat_right", scount[2], 7);
      for (int i = 0; i < 25; i++) cyc(4'b0000, 1'b0);
      // left+right conflict, then up added on the other axis
      clear_counts();
      for (int i = 0; i < 60; i++) cyc(4'b1100, 1'(i % 3 == 0));
      for (int i = 0; i < 90; i++) cyc(4'b1110, 1'(i % 3 == 0));
      check_count("conflict_left", scount[3], 0);
      check_count("conflict_right", scount[2], 0);
      check_count("conflict_up", scount[1], mcount[1]);
      for (int i = 0; i < 25; i++) cyc(4'b0000, 1'b0);
      // release seen together with a tick while repeating, then re-press
      for (int i = 0; i < 20; i++) cyc(4'b0100, 1'b0);
      for (int i = 0; i < 20; i++) cyc(4'b0100, 1'b1);
      for (int i = 0; i < 25; i++) cyc(4'b0000, 1'b1);
      clear_counts();
      for (int i = 0; i < 22; i++) cyc(4'b0100, 1'b0);
      cyc(4'b0100, 1'b1);
      for (int i = 0; i < 2; i++) cyc(4'b0100, 1'b0);
      check_count("repress_right", scount[2], 1);
      for (int i = 0; i < 25; i++) cyc(4'b0000, 1'b0);
      // reset while down is auto-repeating
      for (int i = 0; i < 20; i++) cyc(4'b0001, 1'b0);
      for (int i = 0; i < 20; i++) cyc(4'b0001, 1'b1);
      for (int i = 0; i < 3; i++) cyc(4'b0001, 1'b1, 1'b0);
      clear_counts();
      for (int i = 0; i < D + 3; i++) cyc(4'b0001, 1'b1);
      check_count("reset_quiet_down", scount[0], 0);
      cyc(4'b0001, 1'b1);
      check_count("reset_first_down", scount[0], 1);
      for (int i = 0; i < 25; i++) cyc(4'b0000, 1'b0);
      // random button patterns and ticks
      clear_counts();
      for (int j = 0; j < 120; j++) begin
         logic [3:0] b;
         int len;
         b = 4'($urandom_range(0, 15));
         len = int'($urandom_range(1, 40));
         for (int i = 0; i < len; i++) cyc(b, 1'($urandom_range(0, 3) == 0));
      end
      for (int i = 0; i < 4; i++) check_count("random_total", scount[i], mcount[i]);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
